// File: rtl/dma_priority_resolver.sv
// DMA request arbitration stage: conditions DREQ, merges software requests, applies masks and
// fixed/rotating priority, and holds a one-hot grant until timing control reports service done.
module dma_priority_resolver #(
    parameter int unsigned SYNC_STAGES = 1,
    parameter logic [3:0]  RESET_MASK  = 4'hF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic [7:0] commandReg,
    input  logic [3:0] autoInit,
    input  logic       maskWrEn,
    input  logic [2:0] maskWrData,
    input  logic       reqWrEn,
    input  logic [2:0] reqWrData,
    input  logic       svcDone,
    input  logic       tc,
    input  logic       dackEn,
    output logic [3:0] VALID_DREQ,
    output logic [1:0] grantCh,
    output logic       hrqReq,
    output logic [3:0] DACK,
    output logic [3:0] maskReg,
    output logic [3:0] reqReg
);

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

    state_e     state;
    logic [1:0] ptr;
    logic [3:0] sync_q [2];
    logic [3:0] dreq_s;
    logic [3:0] eff_req;
    logic [1:0] prio_base;
    logic       win_found;
    logic [1:0] win_ch;
    logic [1:0] idx;
    logic [3:0] mask_d;
    logic [3:0] req_d;
    logic       tc_update;

    // Bits not consumed by this stage (belong to other parts of the controller).
    logic unused_cmd;
    assign unused_cmd = ^{commandReg[5], commandReg[3], commandReg[1:0]};

    // Polarity is normalised before the sync registers so everything downstream is active-high.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q[0] <= 4'h0;
            sync_q[1] <= 4'h0;
        end else begin
            sync_q[0] <= DREQ ^ {4{commandReg[6]}};
            sync_q[1] <= sync_q[0];
        end
    end

    assign dreq_s  = (SYNC_STAGES >= 2) ? sync_q[1] : sync_q[0];
    assign eff_req = commandReg[2] ? 4'h0 : ((dreq_s | reqReg) & ~maskReg);
    assign hrqReq  = (|eff_req) | (state != StIdle);

    // Walk the four channels starting at the highest-priority one; fixed mode starts at ch0.
    always_comb begin
        prio_base = commandReg[4] ? ptr : 2'd0;
        win_found = 1'b0;
        win_ch    = 2'd0;
        idx       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = prio_base + 2'(i);
            if (!win_found && eff_req[idx]) begin
                win_found = 1'b1;
                win_ch    = idx;
            end
        end
    end

    // Terminal-count update first, software writes afterwards so they win on the same bit.
    always_comb begin
        mask_d    = maskReg;
        req_d     = reqReg;
        tc_update = (state == StGrant) && svcDone && tc;
        if (tc_update) begin
            req_d[grantCh] = 1'b0;
            if (!autoInit[grantCh]) begin
                mask_d[grantCh] = 1'b1;
            end
        end
        if (maskWrEn) begin
            mask_d[maskWrData[1:0]] = maskWrData[2];
        end
        if (reqWrEn) begin
            req_d[reqWrData[1:0]] = reqWrData[2];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= StIdle;
            VALID_DREQ <= 4'h0;
            grantCh    <= 2'd0;
            maskReg    <= RESET_MASK;
            reqReg     <= 4'h0;
            ptr        <= 2'd0;
            DACK       <= 4'hF;
        end else begin
            maskReg <= mask_d;
            reqReg  <= req_d;
            DACK    <= ({4{dackEn}} & VALID_DREQ) ^ {4{~commandReg[7]}};
            case (state)
                StIdle: begin
                    if (win_found) begin
                        VALID_DREQ <= 4'b0001 << win_ch;
                        grantCh    <= win_ch;
                        state      <= StGrant;
                    end
                end
                StGrant: begin
                    // Grant is frozen here: new requests, masking and disable do not abort it.
                    if (svcDone) begin
                        VALID_DREQ <= 4'h0;
                        state      <= StRelease;
                        if (commandReg[4]) begin
                            ptr <= grantCh + 2'd1;
                        end
                    end
                end
                StRelease: begin
                    state <= StIdle;
                end
                default: begin
                    VALID_DREQ <= 4'h0;
                    state      <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Self-checking bench for dma_priority_resolver: table-driven arbitration vectors plus
// hand-written multi-cycle sequences; every new grant is checked against a scoreboard queue.
module tb_dma_priority_resolver;

    localparam int unsigned SYNC = 1;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ;
    logic [7:0] commandReg;
    logic [3:0] autoInit;
    logic       maskWrEn;
    logic [2:0] maskWrData;
    logic       reqWrEn;
    logic [2:0] reqWrData;
    logic       svcDone;
    logic       tc;
    logic       dackEn;
    logic [3:0] VALID_DREQ;
    logic [1:0] grantCh;
    logic       hrqReq;
    logic [3:0] DACK;
    logic [3:0] maskReg;
    logic [3:0] reqReg;

    dma_priority_resolver #(
        .SYNC_STAGES(SYNC),
        .RESET_MASK (4'hF)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .DREQ      (DREQ),
        .commandReg(commandReg),
        .autoInit  (autoInit),
        .maskWrEn  (maskWrEn),
        .maskWrData(maskWrData),
        .reqWrEn   (reqWrEn),
        .reqWrData (reqWrData),
        .svcDone   (svcDone),
        .tc        (tc),
        .dackEn    (dackEn),
        .VALID_DREQ(VALID_DREQ),
        .grantCh   (grantCh),
        .hrqReq    (hrqReq),
        .DACK      (DACK),
        .maskReg   (maskReg),
        .reqReg    (reqReg)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] cmd;
        logic [3:0] dreq;
        int         exp_ch;
    } vec_t;

    vec_t       vecs [8];
    int         n_vec = 0;
    int         n_err = 0;
    int         exp_q [$];
    int         mon_c;
    int         cyc;
    logic [3:0] prev_valid = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every rising grant must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (VALID_DREQ != 4'h0 && prev_valid == 4'h0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_grant: got %b expected none", VALID_DREQ);
            end else begin
                mon_c = exp_q.pop_front();
                check("grant_onehot", {28'h0, VALID_DREQ}, 32'h1 << mon_c);
                check("grant_ch", {30'h0, grantCh}, mon_c);
            end
        end
        prev_valid = VALID_DREQ;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        maskWrEn  = 1'b0;
        reqWrEn   = 1'b0;
        svcDone   = 1'b0;
        tc        = 1'b0;
        dackEn    = 1'b0;
        autoInit  = 4'h0;
        DREQ      = {4{commandReg[6]}};
        RESET     = 1'b1;
        tick();
        RESET     = 1'b0;
    endtask

    task automatic unmask_all();
        for (int ch = 0; ch < 4; ch++) begin
            maskWrEn   = 1'b1;
            maskWrData = {1'b0, 2'(ch)};
            tick();
        end
        maskWrEn = 1'b0;
    endtask

    task automatic wait_grant(input string name, output int cycles);
        cycles = 0;
        while (VALID_DREQ == 4'h0 && cycles < 10) begin
            tick();
            cycles++;
        end
        if (VALID_DREQ == 4'h0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no grant expected grant within 10 cycles", name);
        end
    endtask

    task automatic service(input logic tc_v);
        svcDone = 1'b1;
        tc      = tc_v;
        tick();
        svcDone = 1'b0;
        tc      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h00, 4'b1010, 1};
        vecs[1] = '{8'h00, 4'b1000, 3};
        vecs[2] = '{8'h00, 4'b0110, 1};
        vecs[3] = '{8'h00, 4'b1111, 0};
        vecs[4] = '{8'h00, 4'b1100, 2};
        vecs[5] = '{8'h40, 4'b1110, 0};
        vecs[6] = '{8'h40, 4'b0111, 3};
        vecs[7] = '{8'h40, 4'b0000, 0};

        commandReg = 8'h00;
        maskWrData = 3'b000;
        reqWrData  = 3'b000;
        do_reset();
        check("rst_valid", {28'h0, VALID_DREQ}, 32'h0);
        check("rst_grantch", {30'h0, grantCh}, 32'h0);
        check("rst_mask", {28'h0, maskReg}, 32'hF);
        check("rst_req", {28'h0, reqReg}, 32'h0);
        check("rst_dack", {28'h0, DACK}, 32'hF);
        check("rst_hrq", {31'h0, hrqReq}, 32'h0);

        // Single-grant arbitration, fixed priority and DREQ polarity.
        for (int i = 0; i < 8; i++) begin
            commandReg = vecs[i].cmd;
            do_reset();
            unmask_all();
            check("idle_no_grant", {28'h0, VALID_DREQ}, 32'h0);
            exp_q.push_back(vecs[i].exp_ch);
            DREQ = vecs[i].dreq;
            wait_grant("vec", cyc);
            check("latency", cyc, SYNC + 1);
            check("hrq_grant", {31'h0, hrqReq}, 32'h1);
            DREQ = {4{commandReg[6]}};
            service(1'b0);
            check("release", {28'h0, VALID_DREQ}, 32'h0);
        end

        // Re-arbitration after release with the request still held.
        commandReg = 8'h00;
        do_reset();
        unmask_all();
        exp_q.push_back(1);
        DREQ = 4'b1010;
        wait_grant("regrant1", cyc);
        exp_q.push_back(1);
        service(1'b0);
        check("release_valid", {28'h0, VALID_DREQ}, 32'h0);
        check("release_hrq", {31'h0, hrqReq}, 32'h1);
        wait_grant("regrant2", cyc);
        DREQ = 4'b0000;
        service(1'b0);
        tick();
        tick();
        check("hrq_drop", {31'h0, hrqReq}, 32'h0);

        // Rotating priority: serviced channel becomes lowest, pointer wraps.
        commandReg = 8'h10;
        do_reset();
        unmask_all();
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        DREQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant("rotate", cyc);
            if (k == 4) DREQ = 4'b0000;
            service(1'b0);
        end

        // Terminal count with and without autoinitialize, via software request.
        commandReg = 8'h00;
        do_reset();
        unmask_all();
        reqWrEn   = 1'b1;
        reqWrData = 3'b110;
        tick();
        reqWrEn   = 1'b0;
        check("swreq_set", {28'h0, reqReg}, 32'h4);
        exp_q.push_back(2);
        wait_grant("tc_grant", cyc);
        service(1'b1);
        check("tc_mask", {28'h0, maskReg}, 32'h4);
        check("tc_req", {28'h0, reqReg}, 32'h0);
        autoInit   = 4'b0100;
        maskWrEn   = 1'b1;
        maskWrData = 3'b010;
        tick();
        maskWrEn   = 1'b0;
        exp_q.push_back(2);
        reqWrEn    = 1'b1;
        reqWrData  = 3'b110;
        tick();
        reqWrEn    = 1'b0;
        wait_grant("ai_grant", cyc);
        service(1'b1);
        check("ai_mask", {28'h0, maskReg}, 32'h0);
        check("ai_req", {28'h0, reqReg}, 32'h0);

        // Software request on ch3 with DREQ idle; software mask write wins over TC.
        do_reset();
        maskWrEn   = 1'b1;
        maskWrData = 3'b011;
        tick();
        maskWrEn   = 1'b0;
        check("mask_ch3_only", {28'h0, maskReg}, 32'h7);
        reqWrEn    = 1'b1;
        reqWrData  = 3'b111;
        tick();
        reqWrEn    = 1'b0;
        check("swreq_ch3", {28'h0, reqReg}, 32'h8);
        exp_q.push_back(3);
        wait_grant("sw_grant", cyc);
        maskWrEn   = 1'b1;
        maskWrData = 3'b011;
        service(1'b1);
        maskWrEn   = 1'b0;
        check("sw_wins_mask", {28'h0, maskReg}, 32'h7);
        check("tc_clears_req3", {28'h0, reqReg}, 32'h0);
        tick();
        reqWrEn    = 1'b1;
        reqWrData  = 3'b100;
        tick();
        reqWrEn    = 1'b0;
        service(1'b1);
        check("svc_idle_req", {28'h0, reqReg}, 32'h1);
        check("svc_idle_mask", {28'h0, maskReg}, 32'h7);

        // Active-low DREQ and active-high DACK.
        commandReg = 8'hC0;
        do_reset();
        unmask_all();
        exp_q.push_back(0);
        DREQ = 4'b1110;
        wait_grant("pol_grant", cyc);
        check("dack_idle_hi", {28'h0, DACK}, 32'h0);
        dackEn = 1'b1;
        tick();
        check("dack_active_hi", {28'h0, DACK}, 32'h1);
        commandReg = 8'h40;
        tick();
        check("dack_active_lo", {28'h0, DACK}, 32'hE);
        dackEn = 1'b0;

        // Controller disable mid-grant, then reset mid-grant.
        commandReg = 8'h00;
        do_reset();
        unmask_all();
        exp_q.push_back(0);
        DREQ = 4'b0011;
        wait_grant("dis_grant", cyc);
        commandReg = 8'h04;
        tick();
        check("disable_keeps_grant", {28'h0, VALID_DREQ}, 32'h1);
        service(1'b0);
        for (int k = 0; k < 6; k++) tick();
        check("disabled_no_grant", {28'h0, VALID_DREQ}, 32'h0);
        check("disabled_hrq", {31'h0, hrqReq}, 32'h0);
        exp_q.push_back(0);
        commandReg = 8'h00;
        wait_grant("reen_grant", cyc);
        dackEn = 1'b1;
        tick();
        check("dack_pre_reset", {28'h0, DACK}, 32'hE);
        RESET = 1'b1;
        tick();
        check("rst_mid_valid", {28'h0, VALID_DREQ}, 32'h0);
        check("rst_mid_mask", {28'h0, maskReg}, 32'hF);
        check("rst_mid_dack", {28'h0, DACK}, 32'hF);
        RESET  = 1'b0;
        dackEn = 1'b0;
        DREQ   = 4'b0000;
        tick();
        tick();

        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
